// File: rtl/judge_if.sv
// Score-compare request/response bundle: packed class scores in, winning index out.
interface judge_if #(
    parameter int unsigned CLASS_NUM = 3,
    parameter int unsigned D_WL      = 16
) ();
    logic                      in_valid;
    logic [CLASS_NUM*D_WL-1:0] data;
    logic [1:0]                result;
    logic                      o_valid;

    modport master (
        output in_valid,
        output data,
        input  result,
        input  o_valid
    );

    modport slave (
        input  in_valid,
        input  data,
        output result,
        output o_valid
    );
endinterface

// File: rtl/judge.sv
// Sequential arg-max over CLASS_NUM signed scores, one class per cycle;
// ties resolve to the lowest index.
module judge #(
    parameter int unsigned CLASS_NUM = 3,
    parameter int unsigned D_WL      = 16
) (
    input logic   clk,
    input logic   rst_n,
    judge_if.slave bus
);
    localparam int unsigned DW    = CLASS_NUM * D_WL;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e                    state_q, state_d;
    logic        [DW-1:0]      data_q, data_d;
    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [D_WL-1:0]    best_q, best_d;
    logic        [1:0]         best_idx_q, best_idx_d;
    logic        [1:0]         result_q, result_d;
    logic                      o_valid_q, o_valid_d;
    logic signed [D_WL-1:0]    cur_score_c;

    // Score of the class currently addressed by the scan counter.
    always_comb begin
        cur_score_c = '0;
        for (int i = 0; i < CLASS_NUM; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                cur_score_c = data_q[i*D_WL +: D_WL];
            end
        end
    end

    // Next-state and datapath update; in_valid only matters in IDLE.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        result_d   = result_q;
        o_valid_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d     = bus.data;
                    best_d     = bus.data[D_WL-1:0];
                    best_idx_d = 2'd0;
                    cnt_d      = CNT_W'(1);
                    state_d    = (CLASS_NUM == 1) ? DONE : SCAN;
                end
            end
            SCAN: begin
                // Strictly greater keeps the earlier index on ties.
                if (cur_score_c > best_q) begin
                    best_d     = cur_score_c;
                    best_idx_d = 2'(cnt_q);
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(CLASS_NUM - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                result_d  = best_idx_q;
                o_valid_d = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            cnt_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            result_q   <= '0;
            o_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            result_q   <= result_d;
            o_valid_q  <= o_valid_d;
        end
    end

    assign bus.result  = result_q;
    assign bus.o_valid = o_valid_q;

endmodule

// File: tb/tb_judge.sv
// Scoreboard bench for judge: stimulus pushes expected index and arrival cycle,
// a monitor compares whenever o_valid appears and checks result holds otherwise.
module tb_judge;
    localparam int unsigned CLASS_NUM = 3;
    localparam int unsigned D_WL      = 16;
    localparam int unsigned LAT       = 3;

    typedef struct {
        logic [1:0] res;
        int         cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    logic [1:0] last_exp = 2'd0;
    exp_t q[$];

    judge_if #(.CLASS_NUM(CLASS_NUM), .D_WL(D_WL)) jif ();

    judge #(.CLASS_NUM(CLASS_NUM), .D_WL(D_WL)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (jif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare pulses against the queue, check hold between pulses.
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL missed_valid: no o_valid at cycle %0d (expected result %0d)", q[0].cyc, q[0].res);
                void'(q.pop_front());
            end
            if (jif.o_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid: o_valid=1 at cycle %0d, required 0", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (jif.result !== e.res || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL result: got %0d at cycle %0d, required %0d at cycle %0d",
                                 jif.result, cyc, e.res, e.cyc);
                    end
                    last_exp = e.res;
                end
            end else begin
                total++;
                if (jif.result !== last_exp) begin
                    bad++;
                    $display("FAIL hold: result=%0d at cycle %0d, required %0d", jif.result, cyc, last_exp);
                end
            end
        end
    end

    // Drive one request at the current negedge; capture happens on the next posedge.
    task automatic issue(input logic [47:0] d, input logic [1:0] e);
        jif.data     = d;
        jif.in_valid = 1'b1;
        q.push_back('{res: e, cyc: cyc + 1 + LAT});
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic single(input logic [47:0] d, input logic [1:0] e);
        issue(d, e);
        @(negedge clk);
        jif.in_valid = 1'b0;
        drain();
    endtask

    task automatic check_idle_outputs(input string name);
        total++;
        if (jif.result !== 2'd0 || jif.o_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s: result=%0d o_valid=%0d, required result=0 o_valid=0", name, jif.result, jif.o_valid);
        end
    endtask

    initial begin
        logic [47:0] bb_d[4];
        logic [1:0]  bb_e[4];
        bb_d[0] = 48'h0001_0002_0003; bb_e[0] = 2'd0;
        bb_d[1] = 48'h0003_0002_0001; bb_e[1] = 2'd2;
        bb_d[2] = 48'h0002_0003_0001; bb_e[2] = 2'd1;
        bb_d[3] = 48'hffff_ffff_ffff; bb_e[3] = 2'd0;

        jif.in_valid = 1'b0;
        jif.data     = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal and max-position cases.
        single(48'h00fe_0707_0f23, 2'd0);
        single(48'h7fff_0001_0002, 2'd2);
        // Class 2 (0x0001) is the only positive score; 0x8000 is negative.
        single(48'h0001_8000_0000, 2'd2);
        // Ties resolve to the lowest index.
        single(48'h0005_0005_0003, 2'd1);
        single(48'h0000_0000_0000, 2'd0);

        // Busy ignore: second strobe during scan must not disturb the first.
        issue(48'h0003_0009_0001, 2'd1);
        @(negedge clk);
        jif.data = 48'h7fff_0000_0000;
        @(negedge clk);
        jif.in_valid = 1'b0;
        drain();
        single(48'h8000_8000_8000, 2'd0);
        single(48'h0000_ffff_fffe, 2'd2);

        // Reset mid-scan: no pulse, outputs cleared, first edge after release accepted.
        jif.data     = 48'h7fff_0000_0000;
        jif.in_valid = 1'b1;
        @(negedge clk);
        jif.in_valid = 1'b0;
        rst_n        = 1'b0;
        last_exp     = 2'd0;
        #1;
        check_idle_outputs("reset_midscan");
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        single(48'h0000_0064_0005, 2'd1);

        // Back-to-back with in_valid held high: one result every 4 cycles.
        for (int k = 0; k < 4; k++) begin
            issue(bb_d[k], bb_e[k]);
            if (k < 3) repeat (LAT + 1) @(negedge clk);
        end
        @(negedge clk);
        jif.in_valid = 1'b0;
        drain();

        repeat (6) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
